// File: rtl/corr_offset_scheduler_pkg.sv
// Shared constants for the correlator offset scheduler: default widths
// matching the correlator core and the FSM state encodings.
package corr_offset_scheduler_pkg;

   // Defaults aligned with the core's offset and bitsum widths
   localparam int OFFSET_W_DEF = 5;
   localparam int SUM_W_DEF    = 16;

   // Frame BRAM slot select width
   localparam int FSEL_W = 2;

   // Scheduler FSM encodings
   localparam int         ST_W         = 3;
   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_LAUNCH    = 3'd1;
   localparam logic [2:0] ST_WAIT_DONE = 3'd2;
   localparam logic [2:0] ST_RELEASE   = 3'd3;
   localparam logic [2:0] ST_ADVANCE   = 3'd4;
   localparam logic [2:0] ST_DONE      = 3'd5;

endpackage

// File: rtl/corr_offset_scheduler_min_tracker.sv
// Running-minimum tracker: keeps the smallest correlation sum seen in a
// search and the offset that produced it. Strict compare, so ties keep the
// earliest raster position.
module corr_min_tracker
   import corr_offset_scheduler_pkg::*;
#(
   parameter int OFFSET_W = OFFSET_W_DEF,
   parameter int SUM_W    = SUM_W_DEF
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                clr_i,
   input  logic                upd_i,
   input  logic [SUM_W-1:0]    sample_i,
   input  logic [OFFSET_W-1:0] x_i,
   input  logic [OFFSET_W-1:0] y_i,
   output logic [SUM_W-1:0]    best_sum_o,
   output logic [OFFSET_W-1:0] best_x_o,
   output logic [OFFSET_W-1:0] best_y_o
);

   logic [SUM_W-1:0]    best_sum_q;
   logic [OFFSET_W-1:0] best_x_q;
   logic [OFFSET_W-1:0] best_y_q;

   // Clear to "nothing found yet" at search start, then take strictly smaller samples
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         best_sum_q <= '1;
         best_x_q   <= '0;
         best_y_q   <= '0;
      end else if (clr_i) begin
         best_sum_q <= '1;
         best_x_q   <= '0;
         best_y_q   <= '0;
      end else if (upd_i && (sample_i < best_sum_q)) begin
         best_sum_q <= sample_i;
         best_x_q   <= x_i;
         best_y_q   <= y_i;
      end
   end

   assign best_sum_o = best_sum_q;
   assign best_x_o   = best_x_q;
   assign best_y_o   = best_y_q;

endmodule

// File: rtl/corr_offset_scheduler.sv
// Offset search sequencer: walks one correlator core over every (x,y)
// offset in raster order, handshaking go/done per offset and keeping the
// minimum correlation sum. Software sees one job per frame pair.
module corr_offset_scheduler
   import corr_offset_scheduler_pkg::*;
#(
   parameter int OFFSET_W = OFFSET_W_DEF,
   parameter int X_RANGE  = 16,
   parameter int Y_RANGE  = 16,
   parameter int SUM_W    = SUM_W_DEF
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                start,
   input  logic                ack,
   input  logic [FSEL_W-1:0]   curr_frame_sel,
   input  logic [FSEL_W-1:0]   prev_frame_sel,
   output logic                core_go,
   input  logic                core_done,
   input  logic [SUM_W-1:0]    core_corr_sum,
   output logic [OFFSET_W-1:0] x_offset,
   output logic [OFFSET_W-1:0] y_offset,
   output logic [FSEL_W-1:0]   curr_frame_bram_offset,
   output logic [FSEL_W-1:0]   prev_frame_bram_offset,
   output logic [OFFSET_W-1:0] best_x,
   output logic [OFFSET_W-1:0] best_y,
   output logic [SUM_W-1:0]    best_sum,
   output logic                busy,
   output logic                done
);

   localparam logic [OFFSET_W-1:0] X_LAST = OFFSET_W'(X_RANGE - 1);
   localparam logic [OFFSET_W-1:0] Y_LAST = OFFSET_W'(Y_RANGE - 1);

   logic [ST_W-1:0]     state_q, state_d;
   logic                start_q;
   logic [OFFSET_W-1:0] x_q, x_d;
   logic [OFFSET_W-1:0] y_q, y_d;
   logic [FSEL_W-1:0]   curr_q, curr_d;
   logic [FSEL_W-1:0]   prev_q, prev_d;
   logic                start_rise;
   logic                trk_clr;
   logic                trk_upd;

   // Only a fresh rising edge launches; a start level held across a job is inert
   assign start_rise = start && !start_q;

   // Next-state and offset stepping; offsets move only in ADVANCE
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      curr_d  = curr_q;
      prev_d  = prev_q;
      case (state_q)
         ST_IDLE: begin
            if (start_rise) begin
               curr_d  = curr_frame_sel;
               prev_d  = prev_frame_sel;
               x_d     = '0;
               y_d     = '0;
               state_d = ST_LAUNCH;
            end
         end
         ST_LAUNCH:    state_d = ST_WAIT_DONE;
         ST_WAIT_DONE: if (core_done) state_d = ST_RELEASE;
         ST_RELEASE:   if (!core_done) state_d = ST_ADVANCE;
         ST_ADVANCE: begin
            if (x_q == X_LAST && y_q == Y_LAST) begin
               state_d = ST_DONE;
            end else if (x_q == X_LAST) begin
               x_d     = '0;
               y_d     = y_q + 1'b1;
               state_d = ST_LAUNCH;
            end else begin
               x_d     = x_q + 1'b1;
               state_d = ST_LAUNCH;
            end
         end
         ST_DONE:      if (ack) state_d = ST_IDLE;
         default:      state_d = ST_IDLE;
      endcase
   end

   // State, offset counters, frame-slot latches and start edge history
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         start_q <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
         curr_q  <= '0;
         prev_q  <= '0;
      end else begin
         state_q <= state_d;
         start_q <= start;
         x_q     <= x_d;
         y_q     <= y_d;
         curr_q  <= curr_d;
         prev_q  <= prev_d;
      end
   end

   assign trk_clr = (state_q == ST_IDLE) && start_rise;
   assign trk_upd = (state_q == ST_WAIT_DONE) && core_done;

   corr_min_tracker #(
      .OFFSET_W (OFFSET_W),
      .SUM_W    (SUM_W)
   ) u_min (
      .clk        (clk),
      .resetn     (resetn),
      .clr_i      (trk_clr),
      .upd_i      (trk_upd),
      .sample_i   (core_corr_sum),
      .x_i        (x_q),
      .y_i        (y_q),
      .best_sum_o (best_sum),
      .best_x_o   (best_x),
      .best_y_o   (best_y)
   );

   // Moore outputs decoded from the registered state
   assign core_go                = (state_q == ST_LAUNCH) || (state_q == ST_WAIT_DONE);
   assign done                   = (state_q == ST_DONE);
   assign busy                   = (state_q != ST_IDLE) && (state_q != ST_DONE);
   assign x_offset               = x_q;
   assign y_offset               = y_q;
   assign curr_frame_bram_offset = curr_q;
   assign prev_frame_bram_offset = prev_q;

endmodule

// File: tb/tb_corr_offset_scheduler.sv
// Bench for corr_offset_scheduler: a 2x2 search instance and a 1x1 instance,
// each driven by a behavioural correlator core, with results checked against
// a raster-order minimum search computed directly from the sum table.
module tb_corr_offset_scheduler;

   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;

   // ---------------- 2x2 instance ----------------
   logic        a_start, a_ack, a_go, a_done, a_cdone, a_busy;
   logic [1:0]  a_cs, a_ps, a_cbo, a_pbo;
   logic [15:0] a_csum, a_bsum;
   logic [4:0]  a_x, a_y, a_bx, a_by;

   corr_offset_scheduler #(.OFFSET_W(5), .X_RANGE(2), .Y_RANGE(2), .SUM_W(16)) u_dut_a (
      .clk(clk), .resetn(resetn), .start(a_start), .ack(a_ack),
      .curr_frame_sel(a_cs), .prev_frame_sel(a_ps),
      .core_go(a_go), .core_done(a_cdone), .core_corr_sum(a_csum),
      .x_offset(a_x), .y_offset(a_y),
      .curr_frame_bram_offset(a_cbo), .prev_frame_bram_offset(a_pbo),
      .best_x(a_bx), .best_y(a_by), .best_sum(a_bsum),
      .busy(a_busy), .done(a_done)
   );

   // ---------------- 1x1 instance ----------------
   logic        b_start, b_ack, b_go, b_done, b_cdone, b_busy;
   logic [1:0]  b_cbo, b_pbo;
   logic [15:0] b_val, b_bsum;
   logic [4:0]  b_x, b_y, b_bx, b_by;

   corr_offset_scheduler #(.OFFSET_W(5), .X_RANGE(1), .Y_RANGE(1), .SUM_W(16)) u_dut_b (
      .clk(clk), .resetn(resetn), .start(b_start), .ack(b_ack),
      .curr_frame_sel(2'd0), .prev_frame_sel(2'd0),
      .core_go(b_go), .core_done(b_cdone), .core_corr_sum(b_val),
      .x_offset(b_x), .y_offset(b_y),
      .curr_frame_bram_offset(b_cbo), .prev_frame_bram_offset(b_pbo),
      .best_x(b_bx), .best_y(b_by), .best_sum(b_bsum),
      .busy(b_busy), .done(b_done)
   );

   // ---------------- behavioural cores ----------------
   logic [15:0] a_tab [0:1][0:1];   // [y][x]
   int          a_lat_min = 0, a_lat_max = 0;
   int          a_cnt, a_cur_lat;
   logic        a_go_q;
   logic [4:0]  a_hx, a_hy;
   int          a_gocnt = 0, a_viol = 0;
   int          a_vx[$], a_vy[$];

   // Core A: done after a per-offset latency, held until one cycle after go falls.
   // Also records each go pulse's offset and flags offset/handshake violations.
   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         a_cdone <= 1'b0; a_cnt <= 0; a_cur_lat <= 0; a_go_q <= 1'b0; a_csum <= '0;
      end else begin
         a_go_q <= a_go;
         if (a_go && !a_go_q) begin
            a_gocnt <= a_gocnt + 1;
            a_vx.push_back(int'(a_x));
            a_vy.push_back(int'(a_y));
            a_hx <= a_x; a_hy <= a_y;
            a_cnt <= 0;
            a_cur_lat <= int'($urandom_range(a_lat_max, a_lat_min));
         end else if (a_go && !a_cdone) begin
            if (a_cnt >= a_cur_lat) begin
               a_cdone <= 1'b1;
               a_csum  <= a_tab[a_y[0]][a_x[0]];
            end else a_cnt <= a_cnt + 1;
         end else if (!a_go) a_cdone <= 1'b0;
         if (((a_go || a_cdone) && !(a_go && !a_go_q) && (a_x !== a_hx || a_y !== a_hy)) ||
             (a_go_q && !a_go && !a_cdone))
            a_viol <= a_viol + 1;
      end
   end

   logic b_go_q;
   int   b_gocnt = 0;
   // Core B: zero-latency core returning the constant b_val
   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         b_cdone <= 1'b0; b_go_q <= 1'b0;
      end else begin
         b_go_q  <= b_go;
         if (b_go && !b_go_q) b_gocnt <= b_gocnt + 1;
         b_cdone <= b_go;
      end
   end

   // ---------------- helpers ----------------
   task automatic ref_a(output logic [15:0] bs, output logic [4:0] bx, output logic [4:0] by);
      bs = 16'hFFFF; bx = 0; by = 0;
      for (int y = 0; y < 2; y++)
         for (int x = 0; x < 2; x++)
            if (a_tab[y][x] < bs) begin
               bs = a_tab[y][x]; bx = 5'(x); by = 5'(y);
            end
   endtask

   // Launch a search on A (start low for one edge, then high) and wait for done.
   // Counts cycles where the latched frame slots differ from expectation; selects
   // are scrambled after the launch so a non-latching design shows up.
   task automatic run_a(input logic [1:0] cs, input logic [1:0] ps,
                        output bit ok, output int fbad);
      fbad = 0; ok = 0;
      @(negedge clk); a_start = 1'b0; a_cs = cs; a_ps = ps;
      @(negedge clk); a_start = 1'b1;
      @(negedge clk); @(negedge clk); a_start = 1'b0;
      a_cs = 2'd2; a_ps = 2'd3;
      for (int i = 0; i < 2000; i++) begin
         if (a_busy && (a_cbo !== cs || a_pbo !== ps)) fbad++;
         if (a_done) begin ok = 1; break; end
         @(negedge clk);
      end
   endtask

   task automatic ack_a();
      @(negedge clk); a_ack = 1'b1;
      @(negedge clk); a_ack = 1'b0;
   endtask

   task automatic check_result_a(input string nm);
      logic [15:0] es; logic [4:0] ex, ey;
      ref_a(es, ex, ey);
      n_total++;
      if (a_bsum !== es || a_bx !== ex || a_by !== ey)
         $display("FAIL %s: got sum=%0d x=%0d y=%0d, want sum=%0d x=%0d y=%0d",
                  nm, a_bsum, a_bx, a_by, es, ex, ey);
      else n_pass++;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      resetn = 1'b0;
      repeat (3) @(negedge clk);
      n_total++;
      if ({a_go, a_busy, a_done, b_go, b_busy, b_done} !== 6'b0)
         $display("FAIL reset_ctrl: got %b want 000000", {a_go, a_busy, a_done, b_go, b_busy, b_done});
      else n_pass++;
      n_total++;
      if ({a_x, a_y, a_bx, a_by, a_cbo, a_pbo} !== 24'h0)
         $display("FAIL reset_offsets: got %h want 0", {a_x, a_y, a_bx, a_by, a_cbo, a_pbo});
      else n_pass++;
      n_total++;
      if (a_bsum !== 16'hFFFF || b_bsum !== 16'hFFFF)
         $display("FAIL reset_best_sum: got %h/%h want ffff", a_bsum, b_bsum);
      else n_pass++;
      resetn = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      bit ok; int fb; int g0;
      a_tab[0][0] = 16'd50; a_tab[0][1] = 16'd30; a_tab[1][0] = 16'd40; a_tab[1][1] = 16'd30;
      a_lat_min = 0; a_lat_max = 0;
      g0 = a_gocnt;
      run_a(2'd0, 2'd0, ok, fb);
      n_total++;
      if (!ok) $display("FAIL basic_done: timeout, done=%b want 1", a_done); else n_pass++;
      n_total++;
      if (a_gocnt - g0 !== 4) $display("FAIL basic_go_pulses: got %0d want 4", a_gocnt - g0);
      else n_pass++;
      check_result_a("basic_best");
      n_total++;
      if (a_busy !== 1'b0) $display("FAIL basic_busy_in_done: got %b want 0", a_busy); else n_pass++;
      // raster order of the last four visits: (0,0),(1,0),(0,1),(1,1)
      n_total++;
      if (a_vx.size() < 4 ||
          {a_vx[a_vx.size()-4], a_vx[a_vx.size()-3], a_vx[a_vx.size()-2], a_vx[a_vx.size()-1]} !== {32'd0, 32'd1, 32'd0, 32'd1} ||
          {a_vy[a_vy.size()-4], a_vy[a_vy.size()-3], a_vy[a_vy.size()-2], a_vy[a_vy.size()-1]} !== {32'd0, 32'd0, 32'd1, 32'd1})
         $display("FAIL basic_raster: visit order wrong, %0d visits recorded", a_vx.size());
      else n_pass++;
      ack_a();
      n_total++;
      if (a_done !== 1'b0) $display("FAIL basic_ack: done=%b want 0", a_done); else n_pass++;
   endtask

   task automatic test_latency();
      bit ok; int fb; int v0; int g0;
      for (int it = 0; it < 10; it++) begin
         for (int y = 0; y < 2; y++)
            for (int x = 0; x < 2; x++)
               a_tab[y][x] = (it % 3 == 0) ? 16'($urandom) : 16'($urandom_range(7, 0));
         if (it == 0)      begin a_lat_min = 20; a_lat_max = 20; end
         else if (it == 1) begin a_lat_min = 0;  a_lat_max = 0;  end
         else              begin a_lat_min = 0;  a_lat_max = 20; end
         v0 = a_viol; g0 = a_gocnt;
         run_a(2'(it), 2'(it + 1), ok, fb);
         n_total++;
         if (!ok || a_gocnt - g0 !== 4)
            $display("FAIL lat_run%0d: done=%b pulses=%0d want done=1 pulses=4", it, ok, a_gocnt - g0);
         else n_pass++;
         check_result_a($sformatf("lat_best%0d", it));
         n_total++;
         if (a_viol !== v0) $display("FAIL lat_stable%0d: violations=%0d want 0", it, a_viol - v0);
         else n_pass++;
         ack_a();
      end
      a_lat_min = 0; a_lat_max = 0;
   endtask

   task automatic test_frame_sel();
      bit ok; int fb;
      a_lat_min = 2; a_lat_max = 5;
      run_a(2'd1, 2'd0, ok, fb);
      n_total++;
      if (!ok || fb !== 0) $display("FAIL frame_sel: done=%b bad_cycles=%0d want 1/0", ok, fb);
      else n_pass++;
      n_total++;
      if (a_cbo !== 2'd1 || a_pbo !== 2'd0)
         $display("FAIL frame_sel_done: got %0d/%0d want 1/0", a_cbo, a_pbo);
      else n_pass++;
      ack_a();
      a_lat_min = 0; a_lat_max = 0;
   endtask

   task automatic test_start_held();
      bit ok; int g0;
      a_lat_min = 1; a_lat_max = 1;
      g0 = a_gocnt;
      @(negedge clk); a_start = 1'b0;
      @(negedge clk); a_start = 1'b1;
      ok = 0;
      for (int i = 0; i < 500; i++) begin
         if (a_done) begin ok = 1; break; end
         @(negedge clk);
      end
      n_total++;
      if (!ok) $display("FAIL held_first: done=%b want 1", a_done); else n_pass++;
      ack_a();
      repeat (10) @(negedge clk);
      n_total++;
      if (a_busy !== 1'b0 || a_gocnt - g0 !== 4)
         $display("FAIL held_no_relaunch: busy=%b pulses=%0d want 0/4", a_busy, a_gocnt - g0);
      else n_pass++;
      a_start = 1'b0;
      @(negedge clk); a_start = 1'b1;
      ok = 0;
      for (int i = 0; i < 500; i++) begin
         if (a_done) begin ok = 1; break; end
         @(negedge clk);
      end
      n_total++;
      if (!ok || a_gocnt - g0 !== 8)
         $display("FAIL held_relaunch: done=%b pulses=%0d want 1/8", ok, a_gocnt - g0);
      else n_pass++;
      a_start = 1'b0;
      ack_a();
      a_lat_min = 0; a_lat_max = 0;
   endtask

   task automatic test_reset_mid();
      bit hit; bit ok; int fb; int g0; int q0;
      a_lat_min = 20; a_lat_max = 20;
      @(negedge clk); a_cs = 2'd3; a_ps = 2'd2;
      @(negedge clk); a_start = 1'b1;
      @(negedge clk); a_start = 1'b0;
      hit = 0;
      for (int i = 0; i < 1000; i++) begin
         if (a_go && a_x == 5'd1 && a_y == 5'd1) begin hit = 1; break; end
         @(negedge clk);
      end
      repeat (3) @(negedge clk);
      n_total++;
      if (!hit || a_go !== 1'b1) $display("FAIL rmid_reach: hit=%b go=%b want 1/1", hit, a_go);
      else n_pass++;
      resetn = 1'b0;
      #1;
      n_total++;
      if ({a_go, a_busy, a_done} !== 3'b0 || {a_x, a_y, a_bx, a_by, a_cbo, a_pbo} !== 24'h0 ||
          a_bsum !== 16'hFFFF)
         $display("FAIL rmid_async: go/busy/done=%b offs=%h sum=%h want 000/0/ffff",
                  {a_go, a_busy, a_done}, {a_x, a_y, a_bx, a_by, a_cbo, a_pbo}, a_bsum);
      else n_pass++;
      @(negedge clk); resetn = 1'b1;
      a_lat_min = 0; a_lat_max = 3;
      a_tab[0][0] = 16'd9; a_tab[0][1] = 16'd7; a_tab[1][0] = 16'd3; a_tab[1][1] = 16'd8;
      g0 = a_gocnt; q0 = a_vx.size();
      run_a(2'd0, 2'd1, ok, fb);
      n_total++;
      if (!ok || a_gocnt - g0 !== 4 || a_vx.size() <= q0 || a_vx[q0] !== 0 || a_vy[q0] !== 0)
         $display("FAIL rmid_restart: done=%b pulses=%0d want 1/4 from (0,0)", ok, a_gocnt - g0);
      else n_pass++;
      check_result_a("rmid_best");
      ack_a();
      a_lat_min = 0; a_lat_max = 0;
   endtask

   task automatic test_single();
      bit ok; int g0;
      b_val = 16'hFFFF;
      g0 = b_gocnt;
      @(negedge clk); b_start = 1'b1;
      @(negedge clk); b_start = 1'b0;
      ok = 0;
      for (int i = 0; i < 100; i++) begin
         if (b_done) begin ok = 1; break; end
         @(negedge clk);
      end
      n_total++;
      if (!ok || b_gocnt - g0 !== 1)
         $display("FAIL single_run: done=%b pulses=%0d want 1/1", ok, b_gocnt - g0);
      else n_pass++;
      n_total++;
      if (b_bsum !== 16'hFFFF || b_bx !== 5'd0 || b_by !== 5'd0)
         $display("FAIL single_best: got %h/%0d/%0d want ffff/0/0", b_bsum, b_bx, b_by);
      else n_pass++;
      b_ack = 1'b1;
      @(negedge clk); b_ack = 1'b0;
      n_total++;
      if (b_done !== 1'b0 || b_busy !== 1'b0)
         $display("FAIL single_ack: done=%b busy=%b want 0/0", b_done, b_busy);
      else n_pass++;
   endtask

   initial begin
      a_start = 0; a_ack = 0; a_cs = 0; a_ps = 0;
      b_start = 0; b_ack = 0; b_val = 16'd0;
      for (int y = 0; y < 2; y++) for (int x = 0; x < 2; x++) a_tab[y][x] = '0;
      test_reset();
      test_basic();
      test_latency();
      test_frame_sel();
      test_start_held();
      test_reset_mid();
      test_single();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/corr_offset_scheduler.md
Name: corr_offset_scheduler

Overview:
- Sequences one correlator core through a full offset search for one frame pair.
- Steps x_offset/y_offset over X_RANGE × Y_RANGE in raster order (y outer, x inner). For each offset: pulses the core's go/done handshake, reads corr_sum, keeps the minimum.
- Sits between the software register interface (start/ack, frame BRAM selects, best-offset result) and the core; software sees one job per frame pair instead of one per offset.

Parameters:
- OFFSET_W, 5, width of x/y offset buses; equals core offset width.
- X_RANGE, 16, number of x offsets searched (0..X_RANGE-1); 1 ≤ X_RANGE ≤ 2^OFFSET_W.
- Y_RANGE, 16, number of y offsets searched (0..Y_RANGE-1); 1 ≤ Y_RANGE ≤ 2^OFFSET_W.
- SUM_W, 16, width of core corr_sum and best_sum.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  level; rising edge seen in IDLE launches a search
- ack  in  1  software acknowledge; releases DONE
- curr_frame_sel  in  2  current-frame BRAM slot, latched at start
- prev_frame_sel  in  2  previous-frame BRAM slot, latched at start
- core_go  out  1  go to correlator core
- core_done  in  1  done from correlator core
- core_corr_sum  in  SUM_W  correlation sum from core
- x_offset  out  OFFSET_W  current x offset to core
- y_offset  out  OFFSET_W  current y offset to core
- curr_frame_bram_offset  out  2  latched curr_frame_sel
- prev_frame_bram_offset  out  2  latched prev_frame_sel
- best_x  out  OFFSET_W  x offset of minimum sum
- best_y  out  OFFSET_W  y offset of minimum sum
- best_sum  out  SUM_W  minimum sum found
- busy  out  1  search in progress
- done  out  1  result valid; held until ack

Behaviour:
- **Reset (async, resetn=0):**
  - State IDLE.
  - core_go, busy and done are 0.
  - x_offset, y_offset, best_x and best_y are 0.
  - best_sum is all ones.
  - Frame offsets are 0.
  - Reset mid-search aborts immediately. The core is reset by the same resetn, so no handshake cleanup is needed.
- **States (registered FSM, Moore outputs):**
  - IDLE:
    - Exit on start=1 && start_d=0, where start_d is start registered one cycle.
    - On exit: latch the frame selects, set x=y=0, set best_sum to all ones, go to LAUNCH.
    - A start held high does not relaunch.
  - LAUNCH: core_go=1; go to WAIT_DONE next cycle.
  - WAIT_DONE:
    - core_go=1; stay until core_done=1.
    - On that cycle, sample core_corr_sum.
    - If the sample is strictly less than best_sum: best_sum←sample, best_x←x_offset, best_y←y_offset.
    - Ties keep the earlier raster position.
    - Go to RELEASE.
  - RELEASE: core_go=0; stay while core_done=1 (the core drops done one cycle after go falls); go to ADVANCE when core_done=0.
  - ADVANCE:
    - If x=X_RANGE-1 and y=Y_RANGE-1: go to DONE_ST.
    - Else if x=X_RANGE-1: x←0, y←y+1, go to LAUNCH.
    - Else: x←x+1, go to LAUNCH.
  - DONE_ST: done=1; go to IDLE when ack=1. An ack arriving on the same cycle DONE_ST is entered is honoured the next cycle.
- **Signal rules:**
  - busy = state ∉ {IDLE, DONE_ST}.
  - x_offset/y_offset change only in ADVANCE. They are stable throughout LAUNCH..RELEASE, as the core requires.
- **Result registers:**
  - best_x, best_y and best_sum stay valid and unchanged from DONE_ST until the next start.
  - The first sample always updates, unless it equals all ones.
- **Ignored inputs:**
  - start outside IDLE is ignored.
  - ack outside DONE_ST is ignored.
  - core_done seen in LAUNCH is ignored.
- **Counters:** offset counters are OFFSET_W wide, with no wrap beyond range limits. X_RANGE=1 makes the search column-only; X_RANGE=Y_RANGE=1 runs exactly one correlation.
- **Latency:** per offset = 1 (LAUNCH) + core latency + 1 (RELEASE min) + 1 (ADVANCE).

Decomposition:
- Shared package/include holds:
  - the state encodings;
  - the default OFFSET_W and SUM_W, aligned with the core's offset and bitsum widths;
  - the 2-bit frame-slot width.
- One natural sub-module: corr_min_tracker, containing the compare/update of best_sum/best_x/best_y with a clear and an update-enable.

Test Plan:
- X_RANGE=Y_RANGE=2; core model returns sums 50,30,40,30 in raster order → exactly 4 go pulses; best_sum=30, best_x=1, best_y=0 (tie keeps first); done=1.
- Core model delays done 0 vs 20 cycles per offset → core_go held high until done; offsets never change while core_go=1 or core_done=1.
- start held high through DONE_ST and ack → no relaunch until start falls and rises again.
- resetn pulsed low during WAIT_DONE at (x=1,y=1) → all outputs return to reset values asynchronously; a new start runs a full search from (0,0).
- curr_frame_sel=1, prev_frame_sel=0 at start, changed to 2/3 mid-search → bram offsets stay 1/0 for the whole search.
- X_RANGE=Y_RANGE=1, core sum 0xFFFF → one correlation; best stays 0xFFFF with best_x=best_y=0; done asserted; ack returns to IDLE next cycle.
